// File: rtl/ram_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ram_ctrl_pkg
// Shared definitions for the request-side RAM access controller:
//   DEPTH       - number of RAM words (256)
//   RAM_ADDR_W  - default RAM address width, derived from DEPTH
//   RAM_DATA_W  - default RAM word width
//   CLR_WORD    - value written to every location by a bulk clear
//   state_e     - controller FSM state encoding
// ----------------------------------------------------------------------------
package ram_ctrl_pkg;

  localparam int DEPTH      = 256;
  localparam int RAM_ADDR_W = $clog2(DEPTH);
  localparam int RAM_DATA_W = 16;

  localparam logic [15:0] CLR_WORD = 16'h0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    CLEAR   = 2'd2
  } state_e;

endpackage

// File: rtl/ram_access_ctrl.sv
// ----------------------------------------------------------------------------
// ram_access_ctrl
// Request-side controller sitting directly in front of a single-port
// block-RAM wrapper that shares clk. Accepts single-word reads/writes over a
// valid/ready handshake, returns read data with a one-cycle strobe, and can
// bulk-clear the whole RAM. Every output except req_ready is registered.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   req_valid  in   request present
//   req_ready  out  request can be accepted this cycle (combinational)
//   req_we     in   1 = write, 0 = read
//   req_addr   in   request address
//   req_wdata  in   write data
//   rsp_valid  out  one-cycle strobe, rsp_rdata holds new read data
//   rsp_rdata  out  read data, held until the next response
//   clr_start  in   request a full-RAM clear (sampled in IDLE only)
//   clr_busy   out  clear in progress
//   clr_done   out  one-cycle strobe after the last clear write
//   ram_we     out  RAM write enable
//   ram_addr   out  RAM address
//   ram_din    out  RAM write data
//   ram_dout   in   RAM read data
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | ready for a request or a clear; writes complete in one cycle
// RD_WAIT | read address presented, counting RAM latency to capture dout
// CLEAR   | sweeping CLR_WORD through every address, one per clock
// ----------------------------------------------------------------------------
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W,
  parameter int RD_LAT = 1            // 1 or 2
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,

  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,

  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,

  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int WAIT_W = 2;

  // Wait counter load: one extra RD_WAIT edge covers the RAM sampling the
  // address, then RD_LAT edges until dout is valid.
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(RD_LAT);

  // Clear counter is one bit wider than the address so that reaching
  // 2**ADDR_W marks the end of the sweep without wrapping.
  localparam logic [ADDR_W:0] CLR_END = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [DATA_W-1:0] CLR_FILL = DATA_W'(CLR_WORD);

  state_e              state_q,     state_d;
  logic                ram_we_q,    ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q,  ram_addr_d;
  logic [DATA_W-1:0]   ram_din_q,   ram_din_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                clr_busy_q,  clr_busy_d;
  logic                clr_done_q,  clr_done_d;
  logic [WAIT_W-1:0]   wait_cnt_q,  wait_cnt_d;
  logic [ADDR_W:0]     clr_cnt_q,   clr_cnt_d;

  logic                req_fire;

  // A pending clr_start masks ready so the clear always wins in IDLE.
  assign req_ready = (state_q == IDLE) && !clr_start;
  assign req_fire  = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    clr_busy_d  = clr_busy_q;
    clr_done_d  = 1'b0;
    wait_cnt_d  = wait_cnt_q;
    clr_cnt_d   = clr_cnt_q;

    case (state_q)
      IDLE: begin
        if (clr_start) begin
          // First clear write (address 0) goes out in the next cycle.
          state_d    = CLEAR;
          ram_we_d   = 1'b1;
          ram_addr_d = '0;
          ram_din_d  = CLR_FILL;
          clr_busy_d = 1'b1;
          clr_cnt_d  = {{ADDR_W{1'b0}}, 1'b1};
        end else if (req_fire) begin
          ram_addr_d = req_addr;
          if (req_we) begin
            ram_we_d  = 1'b1;
            ram_din_d = req_wdata;
          end else begin
            state_d    = RD_WAIT;
            wait_cnt_d = WAIT_LOAD;
          end
        end
      end

      RD_WAIT: begin
        if (wait_cnt_q == '0) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = ram_dout;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end

      CLEAR: begin
        if (clr_cnt_q == CLR_END) begin
          // Last address was written in the cycle just ending.
          state_d    = IDLE;
          clr_busy_d = 1'b0;
          clr_done_d = 1'b1;
          clr_cnt_d  = '0;
        end else begin
          ram_we_d   = 1'b1;
          ram_addr_d = clr_cnt_q[ADDR_W-1:0];
          ram_din_d  = CLR_FILL;
          clr_cnt_d  = clr_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      clr_busy_q  <= 1'b0;
      clr_done_q  <= 1'b0;
      wait_cnt_q  <= '0;
      clr_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      clr_busy_q  <= clr_busy_d;
      clr_done_q  <= clr_done_d;
      wait_cnt_q  <= wait_cnt_d;
      clr_cnt_q   <= clr_cnt_d;
    end
  end

  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign clr_busy  = clr_busy_q;
  assign clr_done  = clr_done_q;

endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
- Request-side controller directly upstream of the 256x16 single-port block-RAM wrapper.
- Accepts single-word read/write requests over a valid/ready handshake and drives the RAM's we/addr/din. Returns read data with a one-cycle response strobe.
- Also provides a bulk-clear command that writes zero to every location.
- All RAM-facing outputs are registered; the RAM shares the controller's clock.

Parameters:
- ADDR_W, 8, RAM address width (depth = 2**ADDR_W = 256)
- DATA_W, 16, RAM word width
- RD_LAT, 1, RAM read latency in clocks from the address-sampling edge to valid dout; legal values 1 or 2

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  request address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle strobe: rsp_rdata holds new read data
- rsp_rdata  out  DATA_W  read data, held until the next response
- clr_start  in  1  request a full-RAM clear
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle strobe at the end of a clear
- ram_we  out  1  to the RAM write enable
- ram_addr  out  ADDR_W  to the RAM address
- ram_din  out  DATA_W  to the RAM data input
- ram_dout  in  DATA_W  from the RAM data output

Behaviour:
- Reset is asynchronous and active-high. On reset:
  - state = IDLE
  - ram_we, ram_addr, ram_din, rsp_valid, rsp_rdata, clr_busy, clr_done = 0
  - wait and clear counters = 0
- States: IDLE, RD_WAIT, CLEAR.
- req_ready = (state == IDLE) && !clr_start. This is combinational; every other output is registered.
- A handshake occurs on a rising edge where req_valid && req_ready.
- Write accepted at edge T:
  - ram_we = 1, ram_addr = req_addr, ram_din = req_wdata during cycle T+1.
  - State stays IDLE, so back-to-back writes proceed at one per clock.
  - ram_we returns to 0 in the next cycle with no write handshake.
- Read accepted at edge T:
  - ram_we = 0, ram_addr = req_addr during cycle T+1; state goes to RD_WAIT.
  - The wait counter counts RD_LAT edges after the RAM samples the address.
  - rsp_rdata is captured from ram_dout, and rsp_valid is high for exactly one cycle. That cycle is T+2+RD_LAT (T+3 when RD_LAT = 1).
  - The state returns to IDLE in the same cycle rsp_valid is high, so req_ready can rise in that cycle.
- At most one read is outstanding. Write-after-read ordering is therefore trivially preserved, and there is no read-after-write hazard, because a write completes at T+1.
- ram_addr and ram_din hold their last values when idle.
- Clear:
  - clr_start is sampled only in IDLE; it is ignored in RD_WAIT and CLEAR.
  - If clr_start and req_valid are high together in IDLE, the clear wins. The request is not accepted (req_ready = 0) and stays pending.
  - CLEAR issues ram_we = 1, ram_din = 0, ram_addr = 0, 1, …, 255 on consecutive cycles: 256 write cycles.
  - clr_busy is high from the cycle after clr_start until the cycle carrying the address-255 write, inclusive.
  - clr_done is high for one cycle on the following cycle, with state back in IDLE and ram_we = 0.
- The clear address counter is ADDR_W+1 bits wide to detect the end; it does not wrap into a second pass.
- Reset mid-read or mid-clear aborts immediately with no response and no clr_done. RAM contents are then whatever was written so far.
- rsp_valid is never asserted for writes.

Decomposition:
- Package ram_ctrl_pkg holds:
  - ADDR_W and DATA_W defaults
  - DEPTH = 256
  - the state enum {IDLE, RD_WAIT, CLEAR}
  - the clear fill value CLR_WORD = 16'h0000
- No sub-module; a single FSM plus counters is sufficient.
- The bench instantiates this block together with the existing 256x16 RAM wrapper, with the RAM signals connected directly.

Test Plan:
- Reset asserted mid-run, with ram_we previously high → all outputs go to 0 asynchronously (before the next clk edge), and req_ready = 1 after release.
- Write 0xBEEF to 0x12 at T → ram_we = 1, ram_addr = 0x12, ram_din = 0xBEEF during T+1. Then read 0x12 → rsp_valid for one cycle at T'+3 with rsp_rdata = 0xBEEF, and req_ready low in T'+1..T'+2.
- Four back-to-back writes to 0x00..0x03 (values 0x1111..0x4444), then reads of each → one write per clock with no stall, and responses return the matching values in order.
- clr_start after filling 0xFF with 0xA5A5 → clr_busy high for 256 cycles and clr_done pulses once. A subsequent read of 0xFF returns 0x0000, and a read of 0x00 returns 0x0000.
- clr_start and a read request to 0x05 in the same cycle → the clear runs first; the read is accepted only on the clr_done cycle or later and returns 0x0000.
- Reset at clear address 0x40, then read 0x80 (pre-filled with 0x5555) → no clr_done, and rsp_rdata = 0x5555 (not cleared).
